fifo_rr_write_arbiter: RTL and testbench

- Shares the single write port of the sync FIFO between NUM_REQ producers, for example the UART RX command path, the sequential pattern writer and debug injectors.
- Uses round-robin arbitration with packet-level grants: a grant is held until the requester's last beat or until MAX_BURST beats have been written.
- Sits between the producers and the FIFO write side.
- Honours fifo_full_in so that no write is ever issued to a full FIFO.

---
 rtl/fifo_rr_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter: shares one sync-FIFO write port between NUM_REQ producers.
// Round-robin grants are held for a whole packet (until the last beat) or until
// MAX_BURST beats have been written, whichever comes first. A full FIFO stalls
// the grant without rotating it.
// Optional feature macro: FIFO_ARB_TIMEOUT_EN -- revokes a grant whose holder has
// been idle for TIMEOUT_CYCLES cycles and pulses timeout_pulse_out.
module fifo_rr_write_arbiter #(
    parameter int DATA_BITS      = 8,
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ-1:0]           req_last_in,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data_in,
    input  logic                         fifo_full_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic                         fifo_wr_en,
    output logic [DATA_BITS-1:0]         fifo_wr_data_out,
    output logic [GW-1:0]                grant_id_out,
    output logic                         grant_active_out,
    output logic                         timeout_pulse_out
);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [GW-1:0]  grant_id_reg, grant_id_next;
    logic [GW-1:0]  last_grant_reg, last_grant_next;
    logic [7:0]     beat_cnt_reg, beat_cnt_next;

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0]  idle_cnt_reg, idle_cnt_next;
`endif

    // Round-robin pick: first valid requester after the last grant holder.
    logic           pick_found;
    logic [GW-1:0]  pick_id;

    // Search last_grant+1, last_grant+2, ... modulo NUM_REQ for a valid requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && req_valid_in[(int'(last_grant_reg) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_id    = GW'((int'(last_grant_reg) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and output decode; outputs are forced low while reset is held
    // so nothing is written in the reset cycle even if a grant was active.
    always_comb begin
        state_next        = state_reg;
        grant_id_next     = grant_id_reg;
        last_grant_next   = last_grant_reg;
        beat_cnt_next     = beat_cnt_reg;
`ifdef FIFO_ARB_TIMEOUT_EN
        idle_cnt_next     = idle_cnt_reg;
`endif
        req_ready_out     = '0;
        fifo_wr_en        = 1'b0;
        fifo_wr_data_out  = '0;
        grant_id_out      = '0;
        grant_active_out  = 1'b0;
        timeout_pulse_out = 1'b0;

        case (state_reg)
            ARB: begin
                if (pick_found) begin
                    grant_id_next = pick_id;
                    beat_cnt_next = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
                    idle_cnt_next = '0;
`endif
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                grant_active_out              = 1'b1;
                grant_id_out                  = grant_id_reg;
                fifo_wr_data_out              = req_data_in[int'(grant_id_reg)*DATA_BITS +: DATA_BITS];
                req_ready_out[grant_id_reg]   = !fifo_full_in;
                fifo_wr_en                    = req_valid_in[grant_id_reg] && !fifo_full_in;

                if (fifo_wr_en) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (req_last_in[grant_id_reg] ||
                        ({1'b0, beat_cnt_reg} + 9'd1 == 9'(MAX_BURST))) begin
                        last_grant_next = grant_id_reg;
                        state_next      = ARB;
                    end
                end

`ifdef FIFO_ARB_TIMEOUT_EN
                // Idle = holder not presenting a beat; a full-stalled valid beat is not idle.
                if (req_valid_in[grant_id_reg]) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == IW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_next     = '0;
                    last_grant_next   = grant_id_reg;
                    state_next        = ARB;
                    timeout_pulse_out = 1'b1;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = ARB;
        endcase

        if (rst) begin
            req_ready_out     = '0;
            fifo_wr_en        = 1'b0;
            fifo_wr_data_out  = '0;
            grant_id_out      = '0;
            grant_active_out  = 1'b0;
            timeout_pulse_out = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any grant immediately.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg      <= ARB;
            grant_id_reg   <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    // Idle-cycle counter for the grant timeout.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Testbench for fifo_rr_write_arbiter: packet-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed write sequences.
module tb_fifo_rr_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int TO = 16;
    localparam int GW = 2;
`ifdef FIFO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid_in = '0;
    logic [NR-1:0]     req_last_in = '0;
    logic [NR*DW-1:0]  req_data_in = '0;
    logic              fifo_full_in = 1'b0;
    logic [NR-1:0]     req_ready_out;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data_out;
    logic [GW-1:0]     grant_id_out;
    logic              grant_active_out;
    logic              timeout_pulse_out;

    fifo_rr_write_arbiter #(
        .DATA_BITS(DW), .NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .req_valid_in(req_valid_in), .req_last_in(req_last_in), .req_data_in(req_data_in),
        .fifo_full_in(fifo_full_in),
        .req_ready_out(req_ready_out), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data_out(fifo_wr_data_out), .grant_id_out(grant_id_out),
        .grant_active_out(grant_active_out), .timeout_pulse_out(timeout_pulse_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Producer packet stores: per requester, beats presented in order.
    logic [DW-1:0] pk_data [NR][64];
    logic          pk_last [NR][64];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] acc = '0;

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        pk_data[r][tail[r]] = d;
        pk_last[r][tail[r]] = l;
        tail[r]++;
    endtask

    // Observation log.
    logic     act_h [4096];
    logic     wr_h  [4096];
    int       wlog_data [256];
    int       wlog_gid  [256];
    int       wlog_cyc  [256];
    int       nw = 0;
    int       npulse = 0;

    // Producer driver: pop accepted beats, then present the next one.
    initial begin
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(posedge clk_in);
            for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
            #1;
            for (int i = 0; i < NR; i++) begin
                req_valid_in[i]            = (head[i] < tail[i]);
                req_last_in[i]             = (head[i] < tail[i]) ? pk_last[i][head[i]] : 1'b0;
                req_data_in[i*DW +: DW]    = (head[i] < tail[i]) ? pk_data[i][head[i]] : '0;
            end
        end
    end

    // Model state: whether a grant is held, by whom, beats/idle so far, last holder.
    bit m_act = 0;
    int m_gid = 0;
    int m_last = NR - 1;
    int m_beats = 0;
    int m_idle = 0;

    // Single compare process: check at negedge, advance the model at posedge.
    initial begin
        logic [NR-1:0] e_ready, s_v, s_l;
        logic [DW-1:0] e_data;
        bit e_wr, e_act, e_to, s_rst;
        int e_gid;
        forever begin
            @(negedge clk_in);
            e_ready = '0; e_wr = 0; e_data = '0; e_gid = 0; e_act = 0; e_to = 0;
            if (!rst && m_act) begin
                e_act  = 1;
                e_gid  = m_gid;
                e_data = req_data_in[m_gid*DW +: DW];
                if (!fifo_full_in) e_ready[m_gid] = 1'b1;
                e_wr   = req_valid_in[m_gid] && !fifo_full_in;
                e_to   = TO_EN && !req_valid_in[m_gid] && (m_idle + 1 == TO);
            end
            chk("ready", int'(req_ready_out), int'(e_ready));
            chk("wr_en", int'(fifo_wr_en), int'(e_wr));
            chk("wr_data", int'(fifo_wr_data_out), int'(e_data));
            chk("grant_id", int'(grant_id_out), e_gid);
            chk("grant_active", int'(grant_active_out), int'(e_act));
            chk("timeout_pulse", int'(timeout_pulse_out), int'(e_to));

            if (cyc < 4096) begin
                act_h[cyc] = grant_active_out;
                wr_h[cyc]  = fifo_wr_en;
            end
            acc = req_valid_in & req_ready_out;
            if (fifo_wr_en && nw < 256) begin
                wlog_data[nw] = fifo_wr_data_out;
                wlog_gid[nw]  = grant_id_out;
                wlog_cyc[nw]  = cyc;
                $display("cycle %0d: write req %0d data 0x%02h", cyc, grant_id_out, fifo_wr_data_out);
                nw++;
            end
            if (timeout_pulse_out) npulse++;
            s_v = req_valid_in; s_l = req_last_in; s_rst = rst;

            @(posedge clk_in);
            if (s_rst) begin
                m_act = 0; m_gid = 0; m_last = NR - 1; m_beats = 0; m_idle = 0;
            end else if (!m_act) begin
                for (int k = 1; k <= NR; k++) begin
                    if (!m_act && s_v[(m_last + k) % NR]) begin
                        m_act = 1; m_gid = (m_last + k) % NR; m_beats = 0; m_idle = 0;
                    end
                end
            end else if (e_wr) begin
                m_beats++;
                m_idle = 0;
                if (s_l[m_gid] || m_beats == MB) begin
                    m_act = 0; m_last = m_gid;
                end
            end else if (s_v[m_gid]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (TO_EN && m_idle == TO) begin
                    m_act = 0; m_last = m_gid; m_idle = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_in); #2 rst = 1'b1;
        repeat (2) @(posedge clk_in);
        #2 rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk_in); #1;
            done = !grant_active_out;
            for (int i = 0; i < NR; i++) if (head[i] < tail[i]) done = 0;
        end
        if (!done) chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk_in); #1;
            done = (nw >= n);
        end
        if (!done) chk("wait_writes_timeout", nw, n);
    endtask

    task automatic wait_valid(input int r, output int c);
        bit done = 0;
        c = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk_in); #1;
            if (req_valid_in[r]) begin done = 1; c = cyc; end
        end
        if (!done) chk("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        int nw0, c0, np0, gap;
        // Hold reset a few cycles, check idle outputs.
        repeat (3) @(posedge clk_in);
        #2 rst = 1'b0;
        @(negedge clk_in); #1;
        chk("reset_active", int'(grant_active_out), 0);
        chk("reset_ready", int'(req_ready_out), 0);

        // 1: single packet from req 2.
        do_reset();
        nw0 = nw;
        push(2, 8'h10, 0); push(2, 8'h11, 0); push(2, 8'h12, 1);
        wait_valid(2, c0);
        wait_idle();
        chk("t1_count", nw - nw0, 3);
        chk("t1_d0", wlog_data[nw0], 'h10);
        chk("t1_d1", wlog_data[nw0+1], 'h11);
        chk("t1_d2", wlog_data[nw0+2], 'h12);
        chk("t1_gid", wlog_gid[nw0], 2);
        chk("t1_arb_cycle", int'(act_h[c0]), 0);
        chk("t1_first_write_cycle", wlog_cyc[nw0], c0 + 1);
        chk("t1_consecutive", wlog_cyc[nw0+2], c0 + 3);
        chk("t1_release", int'(act_h[c0+4]), 0);

        // 2: all four requesters with long packets, forced rotation every 4 beats.
        do_reset();
        nw0 = nw;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 4; j++) push(i, DW'(i*16 + j), 0);
        wait_valid(0, c0);
        wait_idle();
        chk("t2_count", nw - nw0, 16);
        for (int k = 0; k < 16; k++) chk("t2_order", wlog_data[nw0+k], (k/4)*16 + (k%4));
        chk("t2_last_write_cycle", wlog_cyc[nw0+15] - c0, 19);
        chk("t2_arb_gap", wlog_cyc[nw0+4] - wlog_cyc[nw0+3], 2);

        // 3: FIFO full for 5 cycles after beat 2 of req 1.
        do_reset();
        nw0 = nw;
        push(1, 8'h20, 0); push(1, 8'h21, 0); push(1, 8'h22, 0); push(1, 8'h23, 1);
        wait_writes(nw0 + 2);
        @(posedge clk_in); #2 fifo_full_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #2 fifo_full_in = 1'b0;
        wait_idle();
        chk("t3_count", nw - nw0, 4);
        chk("t3_stall_gap", wlog_cyc[nw0+2] - wlog_cyc[nw0+1], 6);
        chk("t3_beat3", wlog_data[nw0+2], 'h22);
        gap = 0;
        for (int c = wlog_cyc[nw0]; c <= wlog_cyc[nw0+3]; c++) if (!act_h[c]) gap++;
        chk("t3_grant_kept", gap, 0);

        // 4: last_grant=0, then req 0 and req 3 contend -> req 3 first.
        do_reset();
        nw0 = nw;
        push(0, 8'h40, 1);
        wait_idle();
        push(0, 8'h41, 1); push(3, 8'h43, 1);
        wait_idle();
        chk("t4_count", nw - nw0, 3);
        chk("t4_first_gid", wlog_gid[nw0+1], 3);
        chk("t4_first_data", wlog_data[nw0+1], 'h43);
        chk("t4_second_data", wlog_data[nw0+2], 'h41);

        // 5: reset on beat 2 of req 1; req 0 wins afterwards.
        do_reset();
        nw0 = nw;
        push(1, 8'h50, 0); push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
        wait_writes(nw0 + 1);
        c0 = cyc;
        @(posedge clk_in); #2 rst = 1'b1;
        push(0, 8'h30, 1);
        @(posedge clk_in); #2 rst = 1'b0;
        wait_idle();
        chk("t5_no_write_in_reset", int'(wr_h[c0+1]), 0);
        chk("t5_idle_after_reset", int'(act_h[c0+2]), 0);
        chk("t5_next_gid", wlog_gid[nw0+1], 0);
        chk("t5_next_data", wlog_data[nw0+1], 'h30);
        chk("t5_resume_data", wlog_data[nw0+2], 'h51);

        // 6: holder goes idle for 100 cycles.
        do_reset();
        nw0 = nw;
        np0 = npulse;
        push(2, 8'h60, 0);
        wait_writes(nw0 + 1);
        repeat (100) @(negedge clk_in);
        #1;
`ifdef FIFO_ARB_TIMEOUT_EN
        chk("t6_pulses", npulse - np0, 1);
        chk("t6_revoked", int'(grant_active_out), 0);
`else
        chk("t6_pulses", npulse - np0, 0);
        chk("t6_held", int'(grant_active_out), 1);
        chk("t6_holder", int'(grant_id_out), 2);
        push(2, 8'h61, 1);
`endif
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
